// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI buffer package.
// Holds the clog2 helper, the simulation delay constant and the
// pointer/count width derivations reused by every EasyAXI buffer.
package easyaxi_pkg;

    // Non-zero only in behavioural models; RTL assigns without delay.
    localparam int DLY = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Pointer width for an array of 'depth' entries (wrap bit kept separately).
    function automatic int ptr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Occupancy counter width: must hold 0..depth+out_reg inclusive.
    function automatic int cnt_w(input int depth, input int out_reg);
        return clog2(depth + out_reg + 1);
    endfunction

endpackage

// File: rtl/easyaxi_flex_fifo_if.sv
// Valid/ready/data channel used on both sides of the EasyAXI FIFO.
//   master: drives valid/data, receives ready
//   slave : receives valid/data, drives ready
interface easyaxi_flex_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/easyaxi_fifo_ptr.sv
// Wrap-aware FIFO pointer for arbitrary (non power-of-two) depths.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : advance pointer by one entry
//   clr_i      : synchronous clear to 0 (wins over inc_i)
//   ptr_o      : current entry index, 0..DEPTH-1
//   wrap_o     : toggles each time the pointer wraps DEPTH-1 -> 0
module easyaxi_fifo_ptr
    import easyaxi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_i,
    input  logic                    clr_i,
    output logic [ptr_w(DEPTH)-1:0] ptr_o,
    output logic                    wrap_o
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = wrap_q;
        if (clr_i) begin
            ptr_d  = '0;
            wrap_d = 1'b0;
        end else if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d  = '0;
                wrap_d = !wrap_q;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;
endmodule

// File: rtl/easyaxi_flex_fifo.sv
// EasyAXI channel buffer: synchronous FIFO with valid/ready on both sides,
// arbitrary depth, occupancy count, almost-full/empty flags, synchronous
// flush and an optional registered output stage (OUT_REG=1).
//   clk, rst_n    : clock, async active-low reset
//   flush         : synchronous clear of all contents (beats push/pop)
//   s_if (slave)  : write channel, valid/ready/data
//   m_if (master) : read channel, valid/ready/data
//   count         : entries held, including the output register
//   almost_full   : count >= AFULL_THRESH (registered)
//   almost_empty  : count <= AEMPTY_THRESH (registered)
module easyaxi_flex_fifo
    import easyaxi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int OUT_REG       = 0,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    easyaxi_flex_fifo_if.slave               s_if,
    easyaxi_flex_fifo_if.master              m_if,
    output logic [cnt_w(DEPTH, OUT_REG)-1:0] count,
    output logic                             almost_full,
    output logic                             almost_empty
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH, OUT_REG);

    if (DEPTH < 2 || AFULL_THRESH > DEPTH + OUT_REG || AEMPTY_THRESH > DEPTH) begin : g_bad_cfg
        $fatal(1, "easyaxi_flex_fifo: illegal DEPTH/AFULL_THRESH/AEMPTY_THRESH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  wr_wrap, rd_wrap;
    logic                  arr_empty;
    logic                  s_ready_q, s_ready_d;
    logic [CNT_W-1:0]      count_q, count_d, arr_cnt_d;
    logic                  afull_q, aempty_q;
    logic                  push, pop, arr_pop;
    logic                  ov_nxt;   // output register valid after this edge

    assign arr_empty = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
    assign push      = s_if.valid && s_ready_q;
    assign pop       = m_if.valid && m_if.ready;

    easyaxi_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (push && !flush),
        .clr_i  (flush),
        .ptr_o  (wr_ptr),
        .wrap_o (wr_wrap)
    );

    easyaxi_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (arr_pop && !flush),
        .clr_i  (flush),
        .ptr_o  (rd_ptr),
        .wrap_o (rd_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr] <= s_if.data;
        end
    end

    if (OUT_REG == 0) begin : g_fwft
        assign m_if.valid = !arr_empty;
        assign m_if.data  = mem_q[rd_ptr];
        assign arr_pop    = pop;
        assign ov_nxt     = 1'b0;
    end else begin : g_oreg
        logic                  ov_q;
        logic [DATA_WIDTH-1:0] od_q;
        logic                  load;

        // Refill from the array head whenever the stage is free or draining.
        assign load    = !arr_empty && (!ov_q || pop);
        assign arr_pop = load;
        assign ov_nxt  = flush ? 1'b0 : (load ? 1'b1 : (pop ? 1'b0 : ov_q));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ov_q <= 1'b0;
                od_q <= '0;
            end else begin
                ov_q <= ov_nxt;
                if (load && !flush) od_q <= mem_q[rd_ptr];
            end
        end

        assign m_if.valid = ov_q;
        assign m_if.data  = od_q;
    end

    // s_ready is the registered inverse of next-cycle array fullness; the
    // array part of the occupancy excludes whatever sits in the output stage.
    always_comb begin
        count_d   = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        arr_cnt_d = count_d - CNT_W'(ov_nxt);
        s_ready_d = flush || (arr_cnt_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            s_ready_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            afull_q   <= (count_d >= CNT_W'(AFULL_THRESH));
            aempty_q  <= (count_d <= CNT_W'(AEMPTY_THRESH));
        end
    end

    assign s_if.ready   = s_ready_q;
    assign count        = count_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
endmodule

// File: tb/tb_easyaxi_flex_fifo.sv
// Bench for easyaxi_flex_fifo: three instances
//   0: DEPTH=4 OUT_REG=0 AFULL=3   1: DEPTH=5 OUT_REG=0   2: DEPTH=4 OUT_REG=1
// A negedge monitor keeps a per-instance scoreboard and occupancy model.
module tb_easyaxi_flex_fifo;
    logic       clk, rst_n;
    logic       fl [3];
    logic       sv [3];
    logic [7:0] sd [3];
    logic       mr [3];
    logic       sr [3];
    logic       mv [3];
    logic [7:0] md [3];
    logic [2:0] cnt [3];
    logic       af [3];
    logic       ae [3];

    int checks = 0;
    int failures = 0;

    logic [7:0] sbq [3][$];
    int         mcnt [3];
    int         pops [3];
    logic       hold [3];
    logic [7:0] hdata [3];

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int D   = (g == 1) ? 5 : 4;
        localparam int ORG = (g == 2) ? 1 : 0;
        localparam int AF  = (g == 0) ? 3 : D - 1;
        easyaxi_flex_fifo_if #(.DATA_WIDTH(8)) s_if ();
        easyaxi_flex_fifo_if #(.DATA_WIDTH(8)) m_if ();
        assign s_if.valid = sv[g];
        assign s_if.data  = sd[g];
        assign m_if.ready = mr[g];
        assign sr[g]      = s_if.ready;
        assign mv[g]      = m_if.valid;
        assign md[g]      = m_if.data;
        easyaxi_flex_fifo #(
            .DATA_WIDTH(8), .DEPTH(D), .OUT_REG(ORG),
            .AFULL_THRESH(AF), .AEMPTY_THRESH(1)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (fl[g]),
            .s_if         (s_if),
            .m_if         (m_if),
            .count        (cnt[g]),
            .almost_full  (af[g]),
            .almost_empty (ae[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int i);
        mr[i] = 1;
        for (int k = 0; k < 40; k++) begin
            if (!mv[i] && sbq[i].size() == 0) break;
            step();
        end
        mr[i] = 0;
        chk($sformatf("drain_empty%0d", i), sbq[i].size(), 0);
        chk($sformatf("drain_mv%0d", i), mv[i], 0);
    endtask

    // Monitor: sample mid-cycle, the handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                sbq[i].delete();
                mcnt[i] = 0;
                hold[i] = 0;
            end else begin
                chk($sformatf("count%0d", i), cnt[i], mcnt[i]);
                if (hold[i]) begin
                    chk($sformatf("hold_valid%0d", i), mv[i], 1);
                    chk($sformatf("hold_data%0d", i), md[i], hdata[i]);
                end
                if (fl[i]) begin
                    sbq[i].delete();
                    mcnt[i] = 0;
                    hold[i] = 0;
                end else begin
                    if (mv[i] && mr[i]) begin
                        pops[i]++;
                        if (sbq[i].size() == 0) chk($sformatf("underflow%0d", i), md[i], 32'hdead);
                        else chk($sformatf("data%0d", i), md[i], sbq[i].pop_front());
                        mcnt[i]--;
                    end
                    if (sv[i] && sr[i]) begin
                        sbq[i].push_back(sd[i]);
                        mcnt[i]++;
                    end
                    hold[i]  = mv[i] && !mr[i];
                    hdata[i] = md[i];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic done;
    initial begin
        rst_n = 0;
        done  = 0;
        for (int i = 0; i < 3; i++) begin
            fl[i] = 0; sv[i] = 1; sd[i] = 8'h11; mr[i] = 0; pops[i] = 0;
        end
        // Reset with s_valid held high
        repeat (3) step();
        chk("rst_sready", sr[0], 0);
        chk("rst_mvalid", mv[0], 0);
        chk("rst_count", cnt[0], 0);
        chk("rst_aempty", ae[0], 1);
        chk("rst_afull", af[0], 0);
        chk("rst_mdata", md[0], 0);
        chk("rst_sready_r", sr[2], 0);
        for (int i = 0; i < 3; i++) sv[i] = 0;
        rst_n = 1;
        #1;
        chk("rel_sready_pre", sr[0], 0);
        step();
        chk("rel_sready", sr[0], 1);

        // Fill DEPTH=4, m_ready low
        for (int k = 0; k < 4; k++) begin
            sd[0] = 8'hA1 + 8'(k);
            sv[0] = 1;
            step();
            chk($sformatf("fill_cnt%0d", k), cnt[0], k + 1);
            chk($sformatf("fill_af%0d", k), af[0], (k + 1 >= 3) ? 1 : 0);
            chk($sformatf("fill_sr%0d", k), sr[0], (k < 3) ? 1 : 0);
        end
        sd[0] = 8'hEE;
        repeat (2) step();
        chk("fill_over_cnt", cnt[0], 4);
        sv[0] = 0;
        drain(0);
        chk("drain_aempty", ae[0], 1);

        // Flush at count 3 with concurrent push of 0x55
        for (int k = 0; k < 3; k++) begin
            sd[0] = 8'hB1 + 8'(k);
            sv[0] = 1;
            step();
        end
        sv[0] = 0;
        chk("pre_flush_cnt", cnt[0], 3);
        fl[0] = 1; sv[0] = 1; sd[0] = 8'h55;
        step();
        fl[0] = 0; sv[0] = 0;
        chk("flush_cnt", cnt[0], 0);
        chk("flush_mvalid", mv[0], 0);
        chk("flush_sready", sr[0], 1);
        chk("flush_aempty", ae[0], 1);
        sd[0] = 8'hC1; sv[0] = 1;
        step();
        sv[0] = 0;
        drain(0);

        // Order and wrap on DEPTH=5 with random m_ready
        fork
            begin
                for (int v = 0; v < 12; v++) begin
                    int g;
                    logic a;
                    sd[1] = 8'(v);
                    sv[1] = 1;
                    g = 0;
                    do begin
                        @(negedge clk);
                        a = sr[1];
                        @(posedge clk);
                        #1;
                        g++;
                    end while (!a && g < 50);
                    if (!a) chk("push_timeout", 0, 1);
                end
                sv[1] = 0;
                done = 1;
            end
            begin
                while (!done) begin
                    mr[1] = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain(1);
        chk("wrap_pops", pops[1], 12);

        // Simultaneous push/pop at count 2
        sv[1] = 1; sd[1] = 8'h20;
        step();
        sd[1] = 8'h21;
        step();
        chk("pp_start_cnt", cnt[1], 2);
        mr[1] = 1;
        for (int k = 0; k < 10; k++) begin
            sd[1] = 8'h22 + 8'(k);
            step();
            chk($sformatf("pp_cnt%0d", k), cnt[1], 2);
        end
        sv[1] = 0;
        drain(1);
        chk("pp_pops", pops[1], 24);

        // OUT_REG=1: latency, capacity DEPTH+1, hold stability
        sd[2] = 8'h30; sv[2] = 1;
        step();
        sv[2] = 0;
        chk("oreg_mv_t", mv[2], 0);
        chk("oreg_cnt_t", cnt[2], 1);
        step();
        chk("oreg_mv_t1", mv[2], 1);
        chk("oreg_md_t1", md[2], 8'h30);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("oreg_sr%0d", k), sr[2], 1);
            sd[2] = 8'h30 + 8'(k); sv[2] = 1;
            step();
            sv[2] = 0;
        end
        chk("oreg_cnt_full", cnt[2], 5);
        chk("oreg_sr_full", sr[2], 0);
        chk("oreg_af", af[2], 1);
        sd[2] = 8'hEE; sv[2] = 1;
        repeat (3) step();
        sv[2] = 0;
        chk("oreg_cnt_hold", cnt[2], 5);
        chk("oreg_md_hold", md[2], 8'h30);
        drain(2);
        chk("oreg_pops", pops[2], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
